// File: rtl/occ_lookup_server_if.sv
// Occurrence-lookup bus: extension-engine request/response plus BWT memory read port.
interface occ_lookup_server_if #(
  parameter int KLS_W  = 32,
  parameter int BLK    = 64,
  parameter int ADDR_W = 32
);
  localparam int WORD_W = 4 * KLS_W + 2 * BLK;

  logic [KLS_W-1:0]      pri_pos_in;
  logic                  bwt_params_valid;
  logic [KLS_W-1:0]      occ_k;
  logic [KLS_W-1:0]      occ_ks;
  logic                  occ_lookup;
  logic [3:0][KLS_W-1:0] occ_val_k;
  logic [3:0][KLS_W-1:0] occ_val_ks;
  logic                  occ_val_valid;
  logic                  busy;
  logic                  overlap_err;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_rd;
  logic [WORD_W-1:0]     mem_rdata;
  logic                  mem_rvalid;

  modport slave (
    input  pri_pos_in, bwt_params_valid, occ_k, occ_ks, occ_lookup, mem_rdata, mem_rvalid,
    output occ_val_k, occ_val_ks, occ_val_valid, busy, overlap_err, mem_addr, mem_rd
  );

  modport master (
    output pri_pos_in, bwt_params_valid, occ_k, occ_ks, occ_lookup, mem_rdata, mem_rvalid,
    input  occ_val_k, occ_val_ks, occ_val_valid, busy, overlap_err, mem_addr, mem_rd
  );
endinterface

// File: rtl/occ_lookup_server.sv
// Turns occ_k/occ_ks into per-symbol occurrence counts from checkpointed BWT blocks.
// Result pulse 4+L cycles after request (same block) or 4+2L (two blocks); requests while busy are dropped.
module occ_lookup_server #(
  parameter int KLS_W  = 32,
  parameter int BLK    = 64,
  parameter int ADDR_W = 32
) (
  input logic                clk,
  input logic                rst_n,
  occ_lookup_server_if.slave bus
);
  localparam int WORD_W = 4 * KLS_W + 2 * BLK;
  localparam int LOG    = $clog2(BLK);
  localparam int CW     = LOG + 1;

  typedef enum logic [2:0] {IDLE, RD_K, WAIT_K, CNT_K, WAIT_KS, CNT_KS} state_t;

  state_t                state_q, state_d;
  logic [KLS_W-1:0]      pri_q;
  logic [ADDR_W-1:0]     k_blk_q, ks_blk_q;
  logic [LOG-1:0]        k_off_q, ks_off_q;
  logic [WORD_W-1:0]     word_q;
  logic [3:0][KLS_W-1:0] val_k_q, val_ks_q;
  logic                  valid_q, err_q;

  logic                  busy, accept, capture, mem_rd;
  logic [ADDR_W-1:0]     mem_addr;
  logic [KLS_W-1:0]      pk, pks;
  logic [LOG-1:0]        cur_off;
  logic [3:0][CW-1:0]    cnt;
  logic [3:0][KLS_W-1:0] occ_res;

  // Positions past the primary slot shift down by one so '$' never occupies a stored symbol.
  function automatic logic [KLS_W-1:0] map_pos(input logic [KLS_W-1:0] x, input logic [KLS_W-1:0] pri);
    return (x > pri) ? x - KLS_W'(1) : x;
  endfunction

  // The result pulse cycle still counts as busy so back-to-back requests start one cycle later.
  assign busy   = (state_q != IDLE) || valid_q;
  assign accept = bus.occ_lookup && !busy;
  assign pk     = map_pos(bus.occ_k, pri_q);
  assign pks    = map_pos(bus.occ_ks, pri_q);

  always_comb begin
    state_d  = state_q;
    mem_rd   = 1'b0;
    mem_addr = '0;
    capture  = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = RD_K;
      RD_K: begin
        mem_rd   = 1'b1;
        mem_addr = k_blk_q;
        state_d  = WAIT_K;
      end
      WAIT_K: if (bus.mem_rvalid) begin
        capture = 1'b1;
        state_d = CNT_K;
      end
      CNT_K: begin
        if (ks_blk_q != k_blk_q) begin
          mem_rd   = 1'b1;
          mem_addr = ks_blk_q;
          state_d  = WAIT_KS;
        end else begin
          state_d = CNT_KS;
        end
      end
      WAIT_KS: if (bus.mem_rvalid) begin
        capture = 1'b1;
        state_d = CNT_KS;
      end
      CNT_KS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cur_off = (state_q == CNT_K) ? k_off_q : ks_off_q;

  always_comb begin
    cnt = '0;
    for (int j = 0; j < BLK; j++) begin
      if (LOG'(j) < cur_off) cnt[word_q[2*j +: 2]] = cnt[word_q[2*j +: 2]] + CW'(1);
    end
    for (int c = 0; c < 4; c++) begin
      occ_res[c] = word_q[2*BLK + c*KLS_W +: KLS_W] + KLS_W'(cnt[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pri_q    <= '0;
      k_blk_q  <= '0;
      ks_blk_q <= '0;
      k_off_q  <= '0;
      ks_off_q <= '0;
      word_q   <= '0;
      val_k_q  <= '0;
      val_ks_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.bwt_params_valid) pri_q <= bus.pri_pos_in;
      if (accept) begin
        k_blk_q  <= ADDR_W'(pk >> LOG);
        k_off_q  <= pk[LOG-1:0];
        ks_blk_q <= ADDR_W'(pks >> LOG);
        ks_off_q <= pks[LOG-1:0];
      end
      if (capture) word_q <= bus.mem_rdata;
      if (state_q == CNT_K) val_k_q <= occ_res;
      if (state_q == CNT_KS) val_ks_q <= occ_res;
      valid_q <= (state_q == CNT_KS);
      if (bus.occ_lookup && busy) err_q <= 1'b1;
    end
  end

  assign bus.occ_val_k     = val_k_q;
  assign bus.occ_val_ks    = val_ks_q;
  assign bus.occ_val_valid = valid_q;
  assign bus.busy          = busy;
  assign bus.overlap_err   = err_q;
  assign bus.mem_rd        = mem_rd;
  assign bus.mem_addr      = mem_addr;
endmodule
